// File: rtl/reg_dump_pkg.sv
// Shared types and defaults for the register-file dump block.
package reg_dump_pkg;

    localparam int NUM_REGS_DEF      = 32;
    localparam int BYTES_PER_REG_DEF = 4;

    // Dump sequencer states; FETCH always lasts exactly one cycle.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/reg_dump_word_serializer.sv
// Loads one 32-bit word and offers it byte by byte, least-significant first,
// over a valid/ready stream.
//
// Handshake: a byte moves when valid and ready are both high at a rising edge.
// valid is a flop (never a function of ready), stays high until the byte is
// taken, and data holds steady while valid is high and ready is low.
module word_serializer
    import reg_dump_pkg::*;
#(
    parameter int BYTES_PER_REG = BYTES_PER_REG_DEF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic [31:0] data_i,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic [7:0]  tx_data_o,
    output logic        last_fire_o
);

    localparam int CW = (BYTES_PER_REG > 1) ? $clog2(BYTES_PER_REG) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(BYTES_PER_REG - 1);

    logic [31:0]   shift_q;
    logic [CW-1:0] byte_cnt;
    logic          valid_q;
    logic          fire;

    assign fire        = valid_q && tx_ready_i;
    assign last_fire_o = fire && (byte_cnt == LAST_CNT);
    assign tx_valid_o  = valid_q;
    assign tx_data_o   = shift_q[7:0];

    // Load a fresh word, then shift one byte out per accepted transfer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shift_q  <= '0;
            byte_cnt <= '0;
            valid_q  <= 1'b0;
        end else if (load_i) begin
            shift_q  <= data_i;
            byte_cnt <= '0;
            valid_q  <= 1'b1;
        end else if (fire) begin
            shift_q  <= {8'h00, shift_q[31:8]};
            byte_cnt <= byte_cnt + 1'b1;
            if (byte_cnt == LAST_CNT) begin
                valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/reg_dump.sv
// Streams registers x0..x(NUM_REGS-1) out of the register file as bytes.
// busy_o lets the core hold off register writes so the dump is a snapshot.
module reg_dump
    import reg_dump_pkg::*;
#(
    parameter int NUM_REGS      = NUM_REGS_DEF,
    parameter int BYTES_PER_REG = BYTES_PER_REG_DEF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    output logic [4:0]  rs_addr_o,
    input  logic [31:0] rs_data_i,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic [7:0]  tx_data_o,
    output logic        busy_o,
    output logic        done_o,
    output state_t      state_o
);

    localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

    state_t     state;
    logic [4:0] reg_idx;
    logic       busy_q;
    logic       done_q;
    logic       last_fire;

    // reg_idx returns to 0 when leaving DONE, so IDLE reads x0 and
    // SEND/DONE keep showing the last fetched register.
    assign rs_addr_o = reg_idx;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign state_o   = state;

    word_serializer #(
        .BYTES_PER_REG (BYTES_PER_REG)
    ) u_ser (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .load_i      (state == FETCH),
        .data_i      (rs_data_i),
        .tx_valid_o  (tx_valid_o),
        .tx_ready_i  (tx_ready_i),
        .tx_data_o   (tx_data_o),
        .last_fire_o (last_fire)
    );

    // Dump sequencer with registered busy/done; never wraps past the last register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            reg_idx <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        reg_idx <= '0;
                        busy_q  <= 1'b1;
                        state   <= FETCH;
                    end
                end
                FETCH: begin
                    state <= SEND;
                end
                SEND: begin
                    if (last_fire) begin
                        if (reg_idx == LAST_IDX) begin
                            done_q <= 1'b1;
                            state  <= DONE;
                        end else begin
                            reg_idx <= reg_idx + 5'd1;
                            state   <= FETCH;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    reg_idx <= '0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
